// File: rtl/sub_sequencer.sv
// Two-requester subtractor sharing one bit-serial full-subtractor cell, round-robin arbitrated.
// Optional signed-overflow output enabled by defining SUB_SEQUENCER_OVF_EN.
module sub_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SUB_SEQUENCER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
   logic [CW-1:0]    cnt_q;
   logic             bin_q, id_q, last_q;
   logic             busy_q, done_q, done_id_q, borrow_q;
`ifdef SUB_SEQUENCER_OVF_EN
   logic             ovf_q;
`endif

   logic sub_d, bout_d, gnt_d, last_bit_d;

   // Shared cell always works on bit 0 of the shifting operand registers.
   assign sub_d      = a_q[0] ^ b_q[0] ^ bin_q;
   assign bout_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
   // Requester 1 wins when alone, or on a tie when requester 0 was served last.
   assign gnt_d      = req[1] & (~req[0] | ~last_q);
   assign last_bit_d = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         cnt_q     <= '0;
         bin_q     <= 1'b0;
         id_q      <= 1'b0;
         last_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         diff_q    <= '0;
         borrow_q  <= 1'b0;
`ifdef SUB_SEQUENCER_OVF_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (|req) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  a_q     <= gnt_d ? a1 : a0;
                  b_q     <= gnt_d ? b1 : b0;
                  id_q    <= gnt_d;
                  last_q  <= gnt_d;
                  cnt_q   <= '0;
                  bin_q   <= 1'b0;
               end
            end
            RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               res_q <= {sub_d, res_q[WIDTH-1:1]};
               bin_q <= bout_d;
               cnt_q <= cnt_q + 1'b1;
               if (last_bit_d) begin
                  // a_q[0]/b_q[0] hold the operand MSBs on this final bit.
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  diff_q    <= {sub_d, res_q[WIDTH-1:1]};
                  borrow_q  <= bout_d;
                  done_id_q <= id_q;
`ifdef SUB_SEQUENCER_OVF_EN
                  ovf_q     <= (a_q[0] != b_q[0]) & (sub_d != a_q[0]);
`endif
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign diff    = diff_q;
   assign borrow  = borrow_q;
`ifdef SUB_SEQUENCER_OVF_EN
   assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_sub_sequencer.sv
// Directed bench for sub_sequencer (WIDTH=4); ovf checks compiled in with SUB_SEQUENCER_OVF_EN.
module tb_sub_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic       busy, done, done_id, borrow;
   logic [3:0] diff;
`ifdef SUB_SEQUENCER_OVF_EN
   logic       ovf;
`endif

   int checks = 0;
   int failures = 0;

   sub_sequencer #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .busy(busy), .done(done), .done_id(done_id),
      .diff(diff), .borrow(borrow)
`ifdef SUB_SEQUENCER_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ovf(input string tag, input logic exp);
`ifdef SUB_SEQUENCER_OVF_EN
      check_val({tag, ".ovf"}, {31'd0, ovf}, {31'd0, exp});
`endif
   endtask

   // One transaction from IDLE: accept, run, DONE, back to IDLE.
   task automatic do_op(input string tag, input logic [1:0] r,
                        input logic [3:0] x0, input logic [3:0] y0,
                        input logic [3:0] x1, input logic [3:0] y1,
                        input logic exp_id, input logic [3:0] exp_diff,
                        input logic exp_borrow, input logic exp_ovf,
                        input bit change_ops);
      int n;
      req = r; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
      tick();
      check_val({tag, ".busy_run"}, {31'd0, busy}, 32'd1);
      req = 2'b00;
      if (change_ops) begin
         a0 = ~x0; b0 = x0 ^ 4'd5; a1 = ~x1; b1 = ~y1;
      end
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check_val({tag, ".latency"}, n, 32'd4);
      check_val({tag, ".diff"}, {28'd0, diff}, {28'd0, exp_diff});
      check_val({tag, ".borrow"}, {31'd0, borrow}, {31'd0, exp_borrow});
      check_val({tag, ".done_id"}, {31'd0, done_id}, {31'd0, exp_id});
      check_val({tag, ".busy_done"}, {31'd0, busy}, 32'd1);
      check_ovf(tag, exp_ovf);
      tick();
      check_val({tag, ".done_drop"}, {31'd0, done}, 32'd0);
      check_val({tag, ".busy_idle"}, {31'd0, busy}, 32'd0);
      check_val({tag, ".diff_hold"}, {28'd0, diff}, {28'd0, exp_diff});
      $display("op %s req=%b diff=%0d borrow=%0d id=%0d latency=%0d", tag, r, diff, borrow, done_id, n);
   endtask

   initial begin
      int n;
      logic [3:0] rr_diff [4];
      rr_diff = '{4'd7, 4'd0, 4'd7, 4'd0};

      // Reset state, with a tie held from reset onward.
      req = 2'b11; a0 = 4'd8; b0 = 4'd1; a1 = 4'd2; b1 = 4'd2;
      #1;
      check_val("rst.busy", {31'd0, busy}, 32'd0);
      check_val("rst.done", {31'd0, done}, 32'd0);
      check_val("rst.diff", {28'd0, diff}, 32'd0);
      check_val("rst.borrow", {31'd0, borrow}, 32'd0);
      check_val("rst.done_id", {31'd0, done_id}, 32'd0);
      tick();
      rst_n = 1'b1;

      // Round robin with req=11 held: 0,1,0,1, each done 6 edges apart.
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!done && n < 20);
         check_val($sformatf("rr%0d.spacing", k), n, (k == 0) ? 32'd5 : 32'd6);
         check_val($sformatf("rr%0d.done_id", k), {31'd0, done_id}, k % 2);
         check_val($sformatf("rr%0d.diff", k), {28'd0, diff}, {28'd0, rr_diff[k]});
         check_val($sformatf("rr%0d.borrow", k), {31'd0, borrow}, 32'd0);
         check_ovf($sformatf("rr%0d", k), (k % 2) == 0);
         $display("op rr%0d req=11 diff=%0d borrow=%0d id=%0d spacing=%0d", k, diff, borrow, done_id, n);
      end
      req = 2'b00;
      tick();
      tick();

      do_op("r0_9m3",  2'b01, 4'd9,  4'd3,  4'd0,  4'd0, 1'b0, 4'd6,  1'b0, 1'b1, 1'b0);
      do_op("r1_3m5",  2'b10, 4'd0,  4'd0,  4'd3,  4'd5, 1'b1, 4'd14, 1'b1, 1'b0, 1'b0);
      do_op("r0_fmf",  2'b01, 4'd15, 4'd15, 4'd0,  4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1);
      do_op("r1_12m3", 2'b10, 4'd0,  4'd0,  4'd12, 4'd3, 1'b1, 4'd9,  1'b0, 1'b0, 1'b1);
      do_op("r0_7m8",  2'b01, 4'd7,  4'd8,  4'd0,  4'd0, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0);
      do_op("r0_5m2",  2'b01, 4'd5,  4'd2,  4'd0,  4'd0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0);

      // Reset during the second RUN cycle aborts without done.
      req = 2'b01; a0 = 4'd9; b0 = 4'd3;
      tick();
      req = 2'b00;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("abort.busy", {31'd0, busy}, 32'd0);
      check_val("abort.done", {31'd0, done}, 32'd0);
      check_val("abort.diff", {28'd0, diff}, 32'd0);
      check_val("abort.borrow", {31'd0, borrow}, 32'd0);
      tick();
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done || busy) n++;
      end
      check_val("abort.no_done", n, 32'd0);
      $display("op abort busy=%0d done=%0d diff=%0d", busy, done, diff);

      do_op("r0_0m1", 2'b01, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
